// File: rtl/iomem_periph_hub.sv
// iomem_periph_hub: iomem slave for the PicoSoC top level.
// Decodes four regions: the GPIO register, a FIFO-buffered RNG read port, a user RAM window,
// and an error response for every other address, so a core access always completes.
// Optional build macro IOMEM_STATUS_EN adds a read-only FIFO status word at 0x0300_1004.
//
// state  | meaning
// IDLE   | waiting for iomem_valid; the request is decoded and accepted here
// RAM_RD | RAM read issued, waiting one cycle for the registered RAM output
// RESP   | iomem_ready asserted for one cycle with iomem_rdata
module iomem_periph_hub #(
    parameter int          GPIO_WIDTH = 8,
    parameter int          RAM_WORDS  = 256,
    parameter int          RNG_DEPTH  = 8,
    parameter logic [31:0] ERR_WORD   = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  iomem_valid,
    output logic                  iomem_ready,
    input  logic [3:0]            iomem_wstrb,
    input  logic [31:0]           iomem_addr,
    input  logic [31:0]           iomem_wdata,
    output logic [31:0]           iomem_rdata,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    input  logic                  rng_valid,
    output logic                  rng_ready,
    input  logic [31:0]           rng_data
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int RNG_PW = $clog2(RNG_DEPTH);

    localparam logic [31:0]     GPIO_ADDR = 32'h0300_0000;
    localparam logic [31:0]     RNG_ADDR  = 32'h0300_1000;
    localparam logic [31:0]     RAM_BASE  = 32'h0300_2000;
    localparam logic [31:0]     RAM_BYTES = 32'(RAM_WORDS) << 2;
    localparam logic [RNG_PW:0] CNT_FULL  = (RNG_PW + 1)'(RNG_DEPTH);
`ifdef IOMEM_STATUS_EN
    localparam logic [31:0]     STAT_ADDR = 32'h0300_1004;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAM_RD,
        ST_RESP
    } state_t;

    state_t state, state_nxt;

    logic [GPIO_WIDTH-1:0] gpio_q;
    logic [GPIO_WIDTH-1:0] gpio_nxt;

    logic [31:0]       fifo_mem [RNG_DEPTH];
    logic [RNG_PW-1:0] wr_ptr;
    logic [RNG_PW-1:0] rd_ptr;
    logic [RNG_PW:0]   count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic [31:0]       ram_mem [RAM_WORDS];
    logic [31:0]       ram_q;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_off;

    logic        accept;
    logic        is_write;
    logic        hit_gpio;
    logic        hit_rng;
    logic        hit_ram;
    logic [31:0] resp_word;
`ifdef IOMEM_STATUS_EN
    logic        hit_stat;
    logic [31:0] status_word;
`endif

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign rng_ready  = !fifo_full;
    assign push       = rng_valid && rng_ready;
    assign gpio_out   = gpio_q;
    assign accept     = (state == ST_IDLE) && iomem_valid;
    assign is_write   = |iomem_wstrb;
    assign ram_off    = iomem_addr - RAM_BASE;
    assign ram_idx    = iomem_addr[RAM_AW+1:2];

    // Address decode; an address below RAM_BASE wraps ram_off high and misses the RAM window.
    always_comb begin
        hit_gpio = (iomem_addr[31:2] == GPIO_ADDR[31:2]);
        hit_rng  = (iomem_addr[31:2] == RNG_ADDR[31:2]);
        hit_ram  = (ram_off < RAM_BYTES);
`ifdef IOMEM_STATUS_EN
        hit_stat = (iomem_addr[31:2] == STAT_ADDR[31:2]);
`endif
    end

    // A RNG read pops only when a word was present at acceptance; a same-cycle push is not seen.
    assign pop = accept && hit_rng && !is_write && !fifo_empty;

`ifdef IOMEM_STATUS_EN
    assign status_word = {14'd0, fifo_empty, fifo_full, 16'(count)};
`endif

    // Byte-strobed GPIO update; lanes beyond GPIO_WIDTH simply have no bits to land in.
    always_comb begin
        gpio_nxt = gpio_q;
        for (int b = 0; b < GPIO_WIDTH; b++) begin
            if (iomem_wstrb[b/8]) gpio_nxt[b] = iomem_wdata[b];
        end
    end

    // Single-cycle response word for every region except RAM reads.
    always_comb begin
        resp_word = ERR_WORD;
        if (hit_gpio) begin
            resp_word = 32'(gpio_q);
        end else if (hit_rng) begin
            if (is_write)        resp_word = 32'h0000_0000;
            else if (fifo_empty) resp_word = 32'hFFFF_FFFF;
            else                 resp_word = fifo_mem[rd_ptr];
        end else if (hit_ram) begin
            resp_word = 32'h0000_0000;
`ifdef IOMEM_STATUS_EN
        end else if (hit_stat) begin
            resp_word = status_word;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // FSM next state and the ready pulse.
    always_comb begin
        state_nxt   = state;
        iomem_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iomem_valid) state_nxt = (hit_ram && !is_write) ? ST_RAM_RD : ST_RESP;
            end
            ST_RAM_RD: state_nxt = ST_RESP;
            ST_RESP: begin
                iomem_ready = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response data, GPIO register and FIFO pointers/count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_rdata <= '0;
            gpio_q      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (accept) iomem_rdata <= resp_word;
            if (state == ST_RAM_RD) iomem_rdata <= ram_q;
            if (accept && hit_gpio && is_write) gpio_q <= gpio_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; unreset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rng_data;
    end

    // User RAM with byte-strobed write and registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && hit_ram) begin
            if (is_write) begin
                for (int k = 0; k < 4; k++) begin
                    if (iomem_wstrb[k]) ram_mem[ram_idx][8*k +: 8] <= iomem_wdata[8*k +: 8];
                end
            end else begin
                ram_q <= ram_mem[ram_idx];
            end
        end
    end

endmodule
